// File: rtl/cve2_pkg.sv
// Shared types and constants for the cve2 memory responder.
//   mem_rsp_t           : one response pipeline entry {valid, err, rdata}
//   MEM_RESP_LFSR_TAPS  : Fibonacci tap mask for x^16+x^14+x^13+x^11+1
package cve2_pkg;

    localparam int unsigned MEM_DATA_W = 32;

    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic [MEM_DATA_W-1:0] rdata;
    } mem_rsp_t;

    localparam logic [15:0] MEM_RESP_LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/cve2_mem_resp_stall_gen.sv
// Pseudo-random grant stall generator for the memory responder.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   seed          : nonzero LFSR reset value
//   stall_o       : high when the current grant must be withheld (about 1 in 4 cycles)
module cve2_mem_resp_stall_gen
    import cve2_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] seed,
    output logic        stall_o
);

    logic [15:0] lfsr_q;
    logic        feedback;

    // XOR of the tapped bits is shifted into bit 0.
    assign feedback = ^(lfsr_q & MEM_RESP_LFSR_TAPS);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= seed;
        end else begin
            lfsr_q <= {lfsr_q[14:0], feedback};
        end
    end

    // Decoded straight from the register, so no input-to-output path.
    assign stall_o = (lfsr_q[1:0] == 2'b00);

endmodule

// File: rtl/cve2_mem_responder.sv
// Behavioural memory responder for the cve2 core instruction/data ports.
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   req_i / gnt_o            : request handshake, gnt_o is combinational
//   we_i, be_i, addr_i, wdata_i : request payload (addr_i[1:0] ignored)
//   rvalid_o, rdata_o, err_o : response, RspLatency cycles after the grant
// Optional feature: define CVE2_MEM_RESP_STALL_EN to stall grants pseudo-randomly.
module cve2_mem_responder
    import cve2_pkg::*;
#(
    parameter int unsigned MemSizeBytes = 65536,
    parameter logic [31:0] BaseAddr     = 32'h0000_0000,
    parameter int unsigned RspLatency   = 1,
    parameter logic [15:0] StallSeed    = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned AddrW    = $clog2(MemSizeBytes);
    localparam int unsigned NumWords = MemSizeBytes / 4;
    localparam int unsigned IdxW     = AddrW - 2;

    logic            stall;
    logic            accept;
    logic [31:0]     offset;
    logic            in_range;
    logic [IdxW-1:0] idx;
    mem_rsp_t        rsp_in;
    mem_rsp_t        pipe_q [RspLatency];
    logic [31:0]     mem    [NumWords];

`ifdef CVE2_MEM_RESP_STALL_EN
    cve2_mem_resp_stall_gen u_stall_gen (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .seed    (StallSeed),
        .stall_o (stall)
    );
`else
    logic unused_stall_seed;
    assign unused_stall_seed = ^StallSeed;
    assign stall             = 1'b0;
`endif

    // Grant is forced low while reset is asserted.
    assign gnt_o  = req_i & ~stall & rst_ni;
    assign accept = gnt_o;

    // BaseAddr is aligned to MemSizeBytes, so the offset low bits are the word index.
    assign offset   = addr_i - BaseAddr;
    assign in_range = (addr_i >= BaseAddr) && (offset < 32'(MemSizeBytes));
    assign idx      = offset[AddrW-1:2];

    // Backing array, deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (accept && we_i && in_range) begin
            for (int unsigned n = 0; n < 4; n++) begin
                if (be_i[n]) begin
                    mem[idx][8*n +: 8] <= wdata_i[8*n +: 8];
                end
            end
        end
    end

    // Response entering the pipe; all fields stay zero unless a request is accepted.
    always_comb begin
        rsp_in = '0;
        if (accept) begin
            rsp_in.valid = 1'b1;
            if (!in_range) begin
                rsp_in.err = 1'b1;
            end else if (!we_i) begin
                rsp_in.rdata = mem[idx];
            end
        end
    end

    // Fixed-latency response shift register, no backpressure.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < RspLatency; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= rsp_in;
            for (int unsigned i = 1; i < RspLatency; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign rvalid_o = pipe_q[RspLatency-1].valid;
    assign err_o    = pipe_q[RspLatency-1].err;
    assign rdata_o  = pipe_q[RspLatency-1].rdata;

endmodule

// File: tb/tb_cve2_mem_responder.sv
// Scoreboard bench for cve2_mem_responder.
//   u0: data port, latency 1      u1: instruction port, base 0x1000, 4 KiB
//   u2: latency 3 (pipelining)    u3: latency 4 (reset mid-flight)
module tb_cve2_mem_responder;

    localparam int NI = 4;
    localparam int unsigned LAT [NI] = '{1, 1, 3, 4};

    typedef struct {
        int unsigned cyc;
        logic        err;
        logic [31:0] data;
        logic        dc;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b1;
    logic        req    [NI] = '{default: 1'b0};
    logic        we     [NI] = '{default: 1'b0};
    logic [3:0]  be     [NI] = '{default: 4'h0};
    logic [31:0] addr   [NI] = '{default: 32'h0};
    logic [31:0] wdata  [NI] = '{default: 32'h0};
    logic        gnt    [NI];
    logic        rvalid [NI];
    logic [31:0] rdata  [NI];
    logic        err    [NI];

    exp_t        sb [NI][$];
    exp_t        mon_e;
    int unsigned cyc     = 0;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model [16];

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    cve2_mem_responder #(.RspLatency(1)) u0 (
        .clk_i(clk_i), .rst_ni(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .we_i(we[0]),
        .be_i(be[0]), .addr_i(addr[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]),
        .rdata_o(rdata[0]), .err_o(err[0]));

    // Instruction port: write side tied off.
    cve2_mem_responder #(.MemSizeBytes(4096), .BaseAddr(32'h0000_1000), .RspLatency(1)) u1 (
        .clk_i(clk_i), .rst_ni(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .we_i(1'b0),
        .be_i(4'hF), .addr_i(addr[1]), .wdata_i(32'h0), .rvalid_o(rvalid[1]),
        .rdata_o(rdata[1]), .err_o(err[1]));

    cve2_mem_responder #(.RspLatency(3)) u2 (
        .clk_i(clk_i), .rst_ni(rst_n), .req_i(req[2]), .gnt_o(gnt[2]), .we_i(we[2]),
        .be_i(be[2]), .addr_i(addr[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]),
        .rdata_o(rdata[2]), .err_o(err[2]));

    cve2_mem_responder #(.RspLatency(4)) u3 (
        .clk_i(clk_i), .rst_ni(rst_n), .req_i(req[3]), .gnt_o(gnt[3]), .we_i(we[3]),
        .be_i(be[3]), .addr_i(addr[3]), .wdata_i(wdata[3]), .rvalid_o(rvalid[3]),
        .rdata_o(rdata[3]), .err_o(err[3]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one request, hold it until granted, and queue its expected response.
    task automatic issue(input int i, input logic w, input logic [3:0] b, input logic [31:0] a,
                         input logic [31:0] d, input logic e_err, input logic [31:0] e_data,
                         input logic e_dc);
        exp_t e;
        @(posedge clk_i); #1;
        req[i] = 1'b1; we[i] = w; be[i] = b; addr[i] = a; wdata[i] = d;
        #1;
        for (int k = 0; k < 64 && !gnt[i]; k++) begin
            @(posedge clk_i); #2;
        end
        check_eq($sformatf("u%0d_gnt", i), 32'(gnt[i]), 32'd1);
        e.cyc = cyc + LAT[i]; e.err = e_err; e.data = e_data; e.dc = e_dc;
        sb[i].push_back(e);
    endtask

    task automatic idle(input int i);
        @(posedge clk_i); #1;
        req[i] = 1'b0; we[i] = 1'b0;
        #1 check_eq($sformatf("u%0d_gnt_idle", i), 32'(gnt[i]), 32'd0);
    endtask

    // Response monitor: every rvalid pops the scoreboard, idle outputs must be zero.
    always @(negedge clk_i) begin
        for (int i = 0; i < NI; i++) begin
            if (rvalid[i] === 1'b1) begin
                if (sb[i].size() == 0) begin
                    check_eq($sformatf("u%0d_unexpected_rvalid", i), 32'(rvalid[i]), 32'd0);
                end else begin
                    mon_e = sb[i].pop_front();
                    check_eq($sformatf("u%0d_rsp_cycle", i), cyc, mon_e.cyc);
                    check_eq($sformatf("u%0d_rsp_err", i), 32'(err[i]), 32'(mon_e.err));
                    if (!mon_e.dc) check_eq($sformatf("u%0d_rsp_data", i), rdata[i], mon_e.data);
                end
            end else if (rst_n) begin
                check_eq($sformatf("u%0d_idle_zero", i), rdata[i] | 32'(err[i]) | 32'(rvalid[i]), 32'd0);
            end
        end
    end

    initial begin
        int k;
        int grants;
        logic [31:0] v;
        logic [3:0]  b;

        #1 rst_n = 1'b0;
        req[0] = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("u%0d_rst_gnt", i), 32'(gnt[i]), 32'd0);
            check_eq($sformatf("u%0d_rst_rvalid", i), 32'(rvalid[i]), 32'd0);
            check_eq($sformatf("u%0d_rst_rsp", i), rdata[i] | 32'(err[i]), 32'd0);
        end
        req[0] = 1'b0;
        rst_n = 1'b1;

        // Write then read-after-write on the next cycle.
        issue(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
        issue(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);
        // Read data is never masked by be, and addr[1:0] are ignored.
        issue(0, 1'b0, 4'b0001, 32'h13, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);
        // Byte lanes.
        issue(0, 1'b1, 4'hF, 32'h20, 32'h11223344, 1'b0, 32'h0, 1'b0);
        issue(0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, 1'b0, 32'h0, 1'b0);
        issue(0, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0, 32'h11BB33DD, 1'b0);
        // Out of range: read and a write that would alias word 0x10 if not rejected.
        issue(0, 1'b1, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
        issue(0, 1'b0, 4'hF, 32'h0001_0000, 32'h0, 1'b1, 32'h0, 1'b0);
        issue(0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0);
        issue(0, 1'b1, 4'hF, 32'h0001_0010, 32'h12345678, 1'b1, 32'h0, 1'b0);
        issue(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);
        idle(0);

        // Instruction port with a nonzero base: below, inside and above the window.
        issue(1, 1'b0, 4'hF, 32'h0000_0FFC, 32'h0, 1'b1, 32'h0, 1'b0);
        issue(1, 1'b0, 4'hF, 32'h0000_1000, 32'h0, 1'b0, 32'h0, 1'b1);
        issue(1, 1'b0, 4'hF, 32'h0000_2000, 32'h0, 1'b1, 32'h0, 1'b0);
        idle(1);

        // Randomised read/write mix against a small reference model.
        for (int j = 0; j < 16; j++) begin
            model[j] = $urandom;
            issue(0, 1'b1, 4'hF, 32'h100 + 32'(j * 4), model[j], 1'b0, 32'h0, 1'b0);
        end
        for (int j = 0; j < 32; j++) begin
            k = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                v = $urandom;
                b = 4'($urandom);
                for (int n = 0; n < 4; n++) if (b[n]) model[k][8*n +: 8] = v[8*n +: 8];
                issue(0, 1'b1, b, 32'h100 + 32'(k * 4), v, 1'b0, 32'h0, 1'b0);
            end else begin
                issue(0, 1'b0, 4'($urandom), 32'h100 + 32'(k * 4), 32'h0, 1'b0, model[k], 1'b0);
            end
        end
        idle(0);

        // Latency 3: back-to-back reads give consecutive in-order pulses.
        issue(2, 1'b1, 4'hF, 32'h0, 32'hA0A0A0A0, 1'b0, 32'h0, 1'b0);
        issue(2, 1'b1, 4'hF, 32'h4, 32'hA1A1A1A1, 1'b0, 32'h0, 1'b0);
        issue(2, 1'b1, 4'hF, 32'h8, 32'hA2A2A2A2, 1'b0, 32'h0, 1'b0);
        issue(2, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 32'hA0A0A0A0, 1'b0);
        issue(2, 1'b0, 4'hF, 32'h4, 32'h0, 1'b0, 32'hA1A1A1A1, 1'b0);
        issue(2, 1'b0, 4'hF, 32'h8, 32'h0, 1'b0, 32'hA2A2A2A2, 1'b0);
        idle(2);

        repeat (8) @(posedge clk_i);

        // Latency 4: reset one cycle after the grant discards the response.
        issue(3, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        @(posedge clk_i); #1;
        req[3] = 1'b0;
        rst_n  = 1'b0;
        sb[3].delete();
        req[0] = 1'b1;
        #1 check_eq("u0_gnt_in_reset", 32'(gnt[0]), 32'd0);
        @(posedge clk_i); #1;
        req[0] = 1'b0;
        rst_n  = 1'b1;
        repeat (10) @(posedge clk_i);

        // Array contents survive reset.
        issue(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);
        idle(0);

`ifdef CVE2_MEM_RESP_STALL_EN
        // Request held for 1000 cycles: roughly three grants in four.
        grants = 0;
        @(posedge clk_i); #1;
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0001_0000;
        for (int j = 0; j < 1000; j++) begin
            #1;
            if (gnt[0]) begin
                grants++;
                mon_e.cyc = cyc + 1; mon_e.err = 1'b1; mon_e.data = 32'h0; mon_e.dc = 1'b0;
                sb[0].push_back(mon_e);
            end
            @(posedge clk_i); #1;
        end
        req[0] = 1'b0;
        check_eq("stall_grant_ratio", 32'(grants >= 700 && grants <= 800), 32'd1);
`else
        grants = 0;
`endif

        // Drain with a bounded wait, then every queued response must have appeared.
        for (int j = 0; j < 32; j++) begin
            if (sb[0].size() == 0 && sb[1].size() == 0 && sb[2].size() == 0 && sb[3].size() == 0) break;
            @(posedge clk_i);
        end
        repeat (2) @(posedge clk_i);
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("u%0d_missing_rsp", i), 32'(sb[i].size()), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cve2_mem_responder.md
CVE2_MEM_RESPONDER -- requirements
Module: cve2_mem_responder

Interface
REQ-001 Parameter MemSizeBytes, default 65536, meaning byte size of the backing array; power of two, multiple of 4.
REQ-002 Parameter BaseAddr, default 32'h0000_0000, meaning first mapped byte address; aligned to MemSizeBytes.
REQ-003 Parameter RspLatency, default 1, meaning cycles from grant to rvalid; legal range 1..8.
REQ-004 Parameter StallSeed, default 16'hACE1, meaning nonzero LFSR seed for grant stalling.
REQ-005 clk_i  input  1  clock; rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 req_i  input  1  request valid from core.
REQ-007 gnt_o  output  1  request accepted this cycle.
REQ-008 we_i  input  1  write (1) / read (0).
REQ-009 be_i  input  4  byte enables.
REQ-010 addr_i  input  32  byte address; bits [1:0] ignored.
REQ-011 wdata_i  input  32  write data.
REQ-012 rvalid_o  output  1  response valid, one cycle per accepted request.
REQ-013 rdata_o  output  32  read data, valid with rvalid_o.
REQ-014 err_o  output  1  error response, valid with rvalid_o.

Function
REQ-015 A request SHALL be accepted in a cycle where req_i and gnt_o are both high; at most one per cycle.
REQ-016 gnt_o SHALL be combinational: req_i AND NOT stall, where stall is 0 unless enabled by REQ-030.
REQ-017 An address is in range when BaseAddr <= addr_i < BaseAddr+MemSizeBytes; the word index is (addr_i-BaseAddr)[log2(MemSizeBytes)-1:2].
REQ-018 Accepted in-range write: each byte lane with be_i[n]=1 SHALL be updated at the accepting clock edge; other lanes are unchanged.
REQ-019 Accepted in-range read: the full word SHALL be sampled at the accepting edge; be_i does not mask rdata_o.
REQ-020 Accepted out-of-range request: the array SHALL NOT be modified; the response carries err_o=1, rdata_o=0.
REQ-021 A request accepted at edge T SHALL produce rvalid_o=1 exactly during cycle T+RspLatency; responses SHALL be in acceptance order.
REQ-022 The response path SHALL be a RspLatency-stage shift register of {valid, err, rdata}, advancing every cycle with no backpressure.
REQ-023 Write responses SHALL carry rdata_o=0, err_o=0.
REQ-024 A read accepted the cycle after a write to the same word SHALL return the written data.
REQ-025 When rvalid_o=0, rdata_o and err_o SHALL be 0.
REQ-026 Back-to-back grants SHALL yield back-to-back rvalid_o pulses; up to RspLatency requests may be outstanding.

Reset
REQ-027 While rst_ni=0: gnt_o=0, rvalid_o=0, err_o=0, rdata_o=0, and all pipeline valid bits cleared.
REQ-028 Reset mid-operation SHALL discard all outstanding responses; no rvalid_o pulse follows for requests accepted before reset.
REQ-029 Array contents SHALL NOT be reset; the stall LFSR SHALL reset to StallSeed.

Configuration
REQ-030 With CVE2_MEM_RESP_STALL_EN defined:
- A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle.
- stall = (lfsr[1:0]==2'b00).
- Requests are held by the core until granted.
REQ-031 Without CVE2_MEM_RESP_STALL_EN: no LFSR logic; stall is constant 0; gnt_o = req_i.

Structure
REQ-032 The following SHALL be added to cve2_pkg:
- typedef mem_rsp_t {valid, err, rdata[31:0]}.
- constant MEM_RESP_LFSR_TAPS = 16'hB400.
REQ-033 The LFSR SHALL be a sub-module cve2_mem_resp_stall_gen (clk_i, rst_ni, seed, stall_o), instantiated only under the macro.
REQ-034 Two cve2_mem_responder instances SHALL serve the core's instruction (we_i, be_i, wdata_i tied 0/4'hF/0) and data ports in the bench.

Verification
REQ-035 Write then read: write 32'hDEADBEEF, be=4'hF to BaseAddr+0x10; next-cycle read -> rvalid at T+RspLatency, rdata=32'hDEADBEEF, err=0.
REQ-036 Byte lanes: word=32'h11223344; write 32'hAABBCCDD with be=4'b0101 -> later read returns 32'h11BB33DD.
REQ-037 Out of range: read at BaseAddr+MemSizeBytes -> rvalid with err=1, rdata=0; a following in-range read at 0x0 is unaffected.
REQ-038 Pipelining, RspLatency=3: 3 back-to-back reads to 0x0/0x4/0x8 -> 3 consecutive rvalid pulses at T+3..T+5, data in order.
REQ-039 Reset mid-flight, RspLatency=4: grant at T, rst_ni low at T+1 for 1 cycle -> no rvalid ever for that request.
REQ-040 CVE2_MEM_RESP_STALL_EN, req_i held high 1000 cycles -> grant ratio in 70-80%, every grant answered, no rvalid without a grant.
